rv32_pmp_scan_ctrl: RTL and testbench

Sequential PMP checker. It takes one physical-address access request at a time and scans the PMP regions in priority order, decoding one region per cycle (OFF/TOR/NA4/NAPOT) through a single shared decode and match unit. It returns hit, region index and allow/deny to the LSU/fetch side. It sits between the CSR file (pmpcfg/pmpaddr arrays) and the memory-request path, ahead of the AXI4 master.

---
 rtl/rv32_pmp_pkg.sv | 39 +++
 rtl/rv32_pmp_match_unit.sv | 56 +++++
 rtl/rv32_pmp_scan_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_rv32_pmp_scan_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pmp_pkg.sv
// Shared types, constants and the NAPOT mask helper for the sequential PMP checker.
package rv32_pmp_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        TOR   = 2'd1,
        NA4   = 2'd2,
        NAPOT = 2'd3
    } pmp_amode_e;

    typedef enum logic [1:0] {
        ACC_R = 2'd0,
        ACC_W = 2'd1,
        ACC_X = 2'd2
    } pmp_acc_e;

    localparam logic [1:0] PRIV_M = 2'd3;

    localparam int unsigned PMP_R    = 0;
    localparam int unsigned PMP_W    = 1;
    localparam int unsigned PMP_X    = 2;
    localparam int unsigned PMP_A_LO = 3;
    localparam int unsigned PMP_A_HI = 4;
    localparam int unsigned PMP_L    = 7;

    // Callers zero-extend pmpaddr and truncate the result to their match width, so an
    // all-ones XLEN pmpaddr finds its lowest zero at bit XLEN and yields a zero mask.
    function automatic logic [65:0] napot_mask(input logic [63:0] pmpaddr);
        int unsigned z;
        z = 64;
        for (int i = 63; i >= 0; i--) begin
            if (!pmpaddr[i]) begin
                z = i;
            end
        end
        return {66{1'b1}} << (z + 3);
    endfunction

endpackage

// File: rtl/rv32_pmp_match_unit.sv
// Combinational decode and match of a single PMP region against one access.
module rv32_pmp_match_unit
    import rv32_pmp_pkg::*;
#(
    parameter int unsigned RLEN = 34,
    parameter int unsigned XLEN = 32
) (
    input  logic [RLEN-1:0] addr,
    input  logic [7:0]      cfg,
    input  logic [XLEN-1:0] pmp_addr,
    input  logic [RLEN-1:0] tor_lo,
    input  logic [1:0]      priv,
    input  logic [1:0]      acc,
    output logic            hit,
    output logic            allow
);

    pmp_amode_e      w_mode;
    logic [RLEN-1:0] w_top;
    logic [RLEN-1:0] w_na4_mask;
    logic [RLEN-1:0] w_napot_mask;
    logic            w_unused_cfg;

    assign w_mode       = pmp_amode_e'(cfg[PMP_A_HI:PMP_A_LO]);
    assign w_top        = RLEN'({pmp_addr, 2'b00});
    assign w_na4_mask   = {{(RLEN-2){1'b1}}, 2'b00};
    assign w_napot_mask = RLEN'(napot_mask(64'(pmp_addr)));
    assign w_unused_cfg = ^cfg[6:5];

    always_comb begin
        hit = 1'b0;
        unique case (w_mode)
            OFF:   hit = 1'b0;
            // An empty or inverted range (tor_lo >= top) satisfies neither bound at once.
            TOR:   hit = (addr >= tor_lo) && (addr < w_top);
            NA4:   hit = (addr & w_na4_mask) == (w_top & w_na4_mask);
            NAPOT: hit = (addr & w_napot_mask) == (w_top & w_napot_mask);
            default: hit = 1'b0;
        endcase
    end

    always_comb begin
        allow = 1'b0;
        if ((priv == PRIV_M) && !cfg[PMP_L]) begin
            allow = 1'b1;
        end else begin
            case (pmp_acc_e'(acc))
                ACC_R:   allow = cfg[PMP_R];
                ACC_W:   allow = cfg[PMP_W];
                ACC_X:   allow = cfg[PMP_X];
                default: allow = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/rv32_pmp_scan_ctrl.sv
// Sequential PMP checker: scans one region per cycle through a shared match unit.
// Optional denial log enabled by defining PMP_ERR_LOG_EN.
module rv32_pmp_scan_ctrl
    import rv32_pmp_pkg::*;
#(
    parameter int unsigned NREGION    = 16,
    parameter int unsigned RLEN       = 34,
    parameter int unsigned XLEN       = 32,
    parameter int unsigned AXI_ADDR_W = XLEN,
    localparam int unsigned IDXW      = (NREGION > 1) ? $clog2(NREGION) : 1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [NREGION*8-1:0]    pmp_cfg,
    input  logic [NREGION*XLEN-1:0] pmp_addr,
    input  logic                    pmp_update,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [AXI_ADDR_W-1:0]   req_addr,
    input  logic [1:0]              req_acc,
    input  logic [1:0]              req_priv,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic                    resp_hit,
    output logic [IDXW-1:0]         resp_region,
    output logic                    resp_allow
`ifdef PMP_ERR_LOG_EN
    ,
    output logic                    err_valid,
    output logic [AXI_ADDR_W-1:0]   err_addr,
    output logic [1:0]              err_acc,
    input  logic                    err_clr
`endif
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam logic [IDXW-1:0] LastIdx = IDXW'(NREGION - 1);

    state_e                r_state;
    logic [IDXW-1:0]       r_idx;
    logic [RLEN-1:0]       r_tor_lo;
    logic [AXI_ADDR_W-1:0] r_addr;
    logic [1:0]            r_acc;
    logic [1:0]            r_priv;
    logic                  r_hit;
    logic [IDXW-1:0]       r_region;
    logic                  r_allow;

    state_e                w_state_next;
    logic [IDXW-1:0]       w_idx_next;
    logic [RLEN-1:0]       w_tor_lo_next;
    logic [AXI_ADDR_W-1:0] w_addr_next;
    logic [1:0]            w_acc_next;
    logic [1:0]            w_priv_next;
    logic                  w_hit_next;
    logic [IDXW-1:0]       w_region_next;
    logic                  w_allow_next;

    logic [7:0]            w_cfg;
    logic [XLEN-1:0]       w_paddr;
    logic [RLEN-1:0]       w_addr_ext;
    logic                  w_match_hit;
    logic                  w_match_allow;

    assign req_ready   = (r_state == StIdle) && aresetn;
    assign resp_valid  = (r_state == StResp);
    assign resp_hit    = r_hit;
    assign resp_region = r_region;
    assign resp_allow  = r_allow;
    assign w_addr_ext  = RLEN'(r_addr);

    // Live CSR values of the region under scan; a CSR write restarts the pass instead.
    always_comb begin
        w_cfg   = '0;
        w_paddr = '0;
        for (int i = 0; i < NREGION; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_cfg   = pmp_cfg[8*i +: 8];
                w_paddr = pmp_addr[XLEN*i +: XLEN];
            end
        end
    end

    rv32_pmp_match_unit #(
        .RLEN (RLEN),
        .XLEN (XLEN)
    ) u_match (
        .addr     (w_addr_ext),
        .cfg      (w_cfg),
        .pmp_addr (w_paddr),
        .tor_lo   (r_tor_lo),
        .priv     (r_priv),
        .acc      (r_acc),
        .hit      (w_match_hit),
        .allow    (w_match_allow)
    );

    always_comb begin
        w_state_next  = r_state;
        w_idx_next    = r_idx;
        w_tor_lo_next = r_tor_lo;
        w_addr_next   = r_addr;
        w_acc_next    = r_acc;
        w_priv_next   = r_priv;
        w_hit_next    = r_hit;
        w_region_next = r_region;
        w_allow_next  = r_allow;
        unique case (r_state)
            StIdle: begin
                if (req_valid && req_ready) begin
                    w_addr_next   = req_addr;
                    w_acc_next    = req_acc;
                    w_priv_next   = req_priv;
                    w_idx_next    = '0;
                    w_tor_lo_next = '0;
                    w_state_next  = StScan;
                end
            end
            StScan: begin
                if (pmp_update) begin
                    w_idx_next    = '0;
                    w_tor_lo_next = '0;
                end else if (w_match_hit) begin
                    w_hit_next    = 1'b1;
                    w_region_next = r_idx;
                    w_allow_next  = w_match_allow;
                    w_state_next  = StResp;
                end else if (r_idx == LastIdx) begin
                    w_hit_next    = 1'b0;
                    w_region_next = '0;
                    w_allow_next  = (r_priv == PRIV_M);
                    w_state_next  = StResp;
                end else begin
                    w_tor_lo_next = RLEN'({w_paddr, 2'b00});
                    w_idx_next    = r_idx + IDXW'(1);
                end
            end
            StResp: begin
                if (resp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= StIdle;
            r_idx    <= '0;
            r_tor_lo <= '0;
            r_addr   <= '0;
            r_acc    <= '0;
            r_priv   <= '0;
            r_hit    <= 1'b0;
            r_region <= '0;
            r_allow  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_idx    <= w_idx_next;
            r_tor_lo <= w_tor_lo_next;
            r_addr   <= w_addr_next;
            r_acc    <= w_acc_next;
            r_priv   <= w_priv_next;
            r_hit    <= w_hit_next;
            r_region <= w_region_next;
            r_allow  <= w_allow_next;
        end
    end

`ifdef PMP_ERR_LOG_EN
    logic                  r_err_valid;
    logic [AXI_ADDR_W-1:0] r_err_addr;
    logic [1:0]            r_err_acc;
    logic                  w_deny_out;

    assign w_deny_out = (r_state == StResp) && resp_ready && !r_allow;

    // A denial arriving together with err_clr replaces the old entry rather than being lost.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_err_valid <= 1'b0;
            r_err_addr  <= '0;
            r_err_acc   <= '0;
        end else if (w_deny_out && (!r_err_valid || err_clr)) begin
            r_err_valid <= 1'b1;
            r_err_addr  <= r_addr;
            r_err_acc   <= r_acc;
        end else if (err_clr) begin
            r_err_valid <= 1'b0;
        end
    end

    assign err_valid = r_err_valid;
    assign err_addr  = r_err_addr;
    assign err_acc   = r_err_acc;
`endif

endmodule

// File: tb/tb_rv32_pmp_scan_ctrl.sv
// Directed self-checking bench for rv32_pmp_scan_ctrl (covers PMP_ERR_LOG_EN when defined).
module tb_rv32_pmp_scan_ctrl;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [127:0] pmp_cfg;
    logic [511:0] pmp_addr;
    logic         pmp_update;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic [1:0]   req_acc;
    logic [1:0]   req_priv;
    logic         resp_valid;
    logic         resp_ready;
    logic         resp_hit;
    logic [3:0]   resp_region;
    logic         resp_allow;
`ifdef PMP_ERR_LOG_EN
    logic         err_valid;
    logic [31:0]  err_addr;
    logic [1:0]   err_acc;
    logic         err_clr;
`endif

    int n_cmp = 0;
    int n_err = 0;

    rv32_pmp_scan_ctrl #(
        .NREGION    (16),
        .RLEN       (34),
        .XLEN       (32),
        .AXI_ADDR_W (32)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .pmp_cfg     (pmp_cfg),
        .pmp_addr    (pmp_addr),
        .pmp_update  (pmp_update),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_acc     (req_acc),
        .req_priv    (req_priv),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_hit    (resp_hit),
        .resp_region (resp_region),
        .resp_allow  (resp_allow)
`ifdef PMP_ERR_LOG_EN
        ,
        .err_valid   (err_valid),
        .err_addr    (err_addr),
        .err_acc     (err_acc),
        .err_clr     (err_clr)
`endif
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_region(input int i, input logic [7:0] cfg, input logic [31:0] addr);
        pmp_cfg[8*i +: 8]   = cfg;
        pmp_addr[32*i +: 32] = addr;
    endtask

    task automatic clear_regions();
        pmp_cfg  = '0;
        pmp_addr = '0;
    endtask

    // Returns cycles from the handshake cycle to the first cycle with resp_valid high.
    task automatic do_req(input logic [31:0] a, input logic [1:0] acc, input logic [1:0] priv,
                          input int upd_at, output int lat);
        @(negedge aclk);
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_addr  = a;
        req_acc   = acc;
        req_priv  = priv;
        @(posedge aclk);
        @(negedge aclk);
        req_valid  = 1'b0;
        lat        = 0;
        pmp_update = (upd_at == 0);
        while (!resp_valid && lat < 200) begin
            @(negedge aclk);
            lat++;
            pmp_update = (lat == upd_at) && !resp_valid;
        end
        pmp_update = 1'b0;
        lat        = lat + 1;
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        @(negedge aclk);
        resp_ready = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input int lat, input int exp_lat,
                               input logic hit, input logic [3:0] region, input logic allow);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_hit"}, 64'(resp_hit), 64'(hit));
        chk({tag, "_region"}, 64'(resp_region), 64'(region));
        chk({tag, "_allow"}, 64'(resp_allow), 64'(allow));
    endtask

    initial begin
        int  lat;
        logic saw;
        aresetn    = 1'b0;
        pmp_update = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_acc    = '0;
        req_priv   = '0;
        resp_ready = 1'b0;
`ifdef PMP_ERR_LOG_EN
        err_clr    = 1'b0;
`endif
        clear_regions();

        #2;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_hit", 64'(resp_hit), 64'd0);
        chk("rst_allow", 64'(resp_allow), 64'd0);
        chk("rst_region", 64'(resp_region), 64'd0);
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;

        // All regions OFF: full 16-region pass, default deny for U, allow for M
        do_req(32'h8000_0000, 2'd0, 2'd0, -1, lat);
        expect_resp("off_u", lat, 17, 1'b0, 4'd0, 1'b0);
        consume();
        do_req(32'h8000_0000, 2'd0, 2'd3, -1, lat);
        expect_resp("off_m", lat, 17, 1'b0, 4'd0, 1'b1);
        consume();

        // NAPOT 4 KiB at 0x8000_0000, RW only
        set_region(0, 8'h1B, 32'h2000_01FF);
        do_req(32'h8000_0FFC, 2'd0, 2'd0, -1, lat);
        expect_resp("napot_rd", lat, 2, 1'b1, 4'd0, 1'b1);
        consume();
        do_req(32'h8000_0FFC, 2'd2, 2'd0, -1, lat);
        expect_resp("napot_x", lat, 2, 1'b1, 4'd0, 1'b0);
        consume();
        do_req(32'h8000_1000, 2'd0, 2'd0, -1, lat);
        expect_resp("napot_out", lat, 17, 1'b0, 4'd0, 1'b0);
        consume();

        // TOR region 2 covers [0x1000_0000, 0x1400_0000), base from OFF region 1
        clear_regions();
        set_region(1, 8'h00, 32'h0400_0000);
        set_region(2, 8'h0D, 32'h0500_0000);
        do_req(32'h1000_0000, 2'd2, 2'd0, -1, lat);
        expect_resp("tor_in", lat, 4, 1'b1, 4'd2, 1'b1);
        consume();
        do_req(32'h1400_0000, 2'd2, 2'd0, -1, lat);
        expect_resp("tor_top", lat, 17, 1'b0, 4'd0, 1'b0);
        consume();
        set_region(2, 8'h0D, 32'h0300_0000);
        do_req(32'h1000_0000, 2'd2, 2'd0, -1, lat);
        expect_resp("tor_inv", lat, 17, 1'b0, 4'd0, 1'b0);
        consume();

        // Locked NA4 at 0x400 binds M mode; unlocked does not
        clear_regions();
        set_region(0, 8'h90, 32'h0000_0100);
        do_req(32'h0000_0402, 2'd1, 2'd3, -1, lat);
        expect_resp("lock_hit", lat, 2, 1'b1, 4'd0, 1'b0);
        consume();
        do_req(32'h0000_0404, 2'd1, 2'd3, -1, lat);
        expect_resp("lock_miss", lat, 17, 1'b0, 4'd0, 1'b1);
        consume();
        set_region(0, 8'h10, 32'h0000_0100);
        do_req(32'h0000_0402, 2'd1, 2'd3, -1, lat);
        expect_resp("unlock_hit", lat, 2, 1'b1, 4'd0, 1'b1);
        consume();

        // Priority: region 3 (R) shadows region 5 (RW)
        clear_regions();
        set_region(3, 8'h19, 32'h2000_01FF);
        set_region(5, 8'h1B, 32'h2000_01FF);
        do_req(32'h8000_0010, 2'd1, 2'd0, -1, lat);
        expect_resp("prio_w", lat, 5, 1'b1, 4'd3, 1'b0);
        consume();

        // Back-pressure: response held while resp_ready is low
        do_req(32'h8000_0010, 2'd0, 2'd0, -1, lat);
        expect_resp("stall", lat, 5, 1'b1, 4'd3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("stall_valid", 64'(resp_valid), 64'd1);
            chk("stall_region", 64'(resp_region), 64'd3);
            chk("stall_allow", 64'(resp_allow), 64'd1);
            chk("stall_req_ready", 64'(req_ready), 64'd0);
        end
        consume();

        // CSR write at idx 4 restarts the pass: region 5 hit 5 cycles later
        set_region(3, 8'h00, 32'h0000_0000);
        do_req(32'h8000_0010, 2'd1, 2'd0, -1, lat);
        expect_resp("r5_plain", lat, 7, 1'b1, 4'd5, 1'b1);
        consume();
        do_req(32'h8000_0010, 2'd1, 2'd0, 4, lat);
        expect_resp("r5_update", lat, 12, 1'b1, 4'd5, 1'b1);
        consume();

        // Reset mid-scan aborts with no response
        clear_regions();
        @(negedge aclk);
        req_valid = 1'b1;
        req_addr  = 32'h8000_0000;
        req_acc   = 2'd0;
        req_priv  = 2'd0;
        @(posedge aclk);
        @(negedge aclk);
        req_valid = 1'b0;
        repeat (3) @(negedge aclk);
        aresetn = 1'b0;
        #1;
        chk("abort_valid", 64'(resp_valid), 64'd0);
        chk("abort_req_ready_rst", 64'(req_ready), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk("abort_req_ready", 64'(req_ready), 64'd1);
        saw = 1'b0;
        repeat (20) begin
            @(negedge aclk);
            if (resp_valid) saw = 1'b1;
        end
        chk("abort_no_resp", 64'(saw), 64'd0);
        do_req(32'h8000_0000, 2'd0, 2'd3, -1, lat);
        expect_resp("post_abort", lat, 17, 1'b0, 4'd0, 1'b1);
        consume();

`ifdef PMP_ERR_LOG_EN
        err_clr = 1'b1;
        @(negedge aclk);
        err_clr = 1'b0;
        chk("err_cleared", 64'(err_valid), 64'd0);
        do_req(32'h8000_0000, 2'd0, 2'd0, -1, lat);
        consume();
        chk("err_valid", 64'(err_valid), 64'd1);
        chk("err_addr", 64'(err_addr), 64'h8000_0000);
        chk("err_acc", 64'(err_acc), 64'd0);
        do_req(32'h9000_0000, 2'd1, 2'd0, -1, lat);
        consume();
        chk("err_sticky_addr", 64'(err_addr), 64'h8000_0000);
        chk("err_sticky_acc", 64'(err_acc), 64'd0);
        err_clr = 1'b1;
        @(negedge aclk);
        err_clr = 1'b0;
        chk("err_clr", 64'(err_valid), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
